// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters, with post-reset fill sweep
module bram_port_arbiter #(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 9,
    parameter logic [DataWidth-1:0] InitValue = '0,
    parameter bit InitOnReset = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [AddrWidth-1:0] addr0,
    input  logic [DataWidth-1:0] wdata0,
    output logic                 gnt0,
    output logic                 rvalid0,
    output logic [DataWidth-1:0] rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [AddrWidth-1:0] addr1,
    input  logic [DataWidth-1:0] wdata1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [DataWidth-1:0] rdata1,
    output logic                 busy,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AddrWidth-1:0] ram_addr,
    output logic [DataWidth-1:0] ram_din,
    input  logic [DataWidth-1:0] ram_dout
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;
    logic [AddrWidth-1:0] cnt;
    logic last, in_init, in_run;
    assign rdata0 = ram_dout;
    assign rdata1 = ram_dout;
    // state, sweep counter, last-granted pointer (1 = requester 0 wins next tie), read-valid flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= InitOnReset ? INIT : RUN;
            cnt     <= '0;
            last    <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= in_init ? cnt + 1'b1 : cnt;
            last    <= gnt1 ? 1'b1 : gnt0 ? 1'b0 : last;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end
    // grant decision, sweep termination and RAM port mux; everything is quiet while reset is high
    always_comb begin
        in_init    = ~reset & (state == INIT);
        in_run     = ~reset & (state == RUN);
        state_next = (in_init && cnt == '1) ? RUN : state;
        gnt0       = in_run & req0 & (~req1 | last);
        gnt1       = in_run & req1 & (~req0 | ~last);
        busy       = reset ? InitOnReset : (state == INIT);
        ram_en     = in_init | gnt0 | gnt1;
        ram_we     = in_init | (gnt0 & we0) | (gnt1 & we1);
        ram_addr   = in_init ? cnt : gnt1 ? addr1 : addr0;
        ram_din    = in_init ? InitValue : gnt1 ? wdata1 : wdata0;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of a 4Kx9 true-dual-port block RAM (write-first, no output register, 1-cycle read latency) between two requesters.
- Uses round-robin arbitration with a req/gnt handshake.
- After reset, sweeps the whole RAM to a fill value before granting any access.
- Sits between client logic (e.g. CPU-side and DMA-side engines) and one RAM port. The other RAM port stays free for an independent clock domain.

Parameters:
- AddrWidth, 12, RAM address width; depth = 2**AddrWidth.
- DataWidth, 9, RAM data width.
- InitValue, 0, data written to every location during the init sweep (DataWidth bits).
- InitOnReset, 1, 1 = run the init sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock for all logic and the RAM port.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request; held until gnt0.
- we0  in  1  requester 0 write (1) / read (0); valid with req0.
- addr0  in  AddrWidth  requester 0 address.
- wdata0  in  DataWidth  requester 0 write data.
- gnt0  out  1  one-cycle pulse: access for requester 0 issued this cycle.
- rvalid0  out  1  rdata0 valid; one cycle after a read grant.
- rdata0  out  DataWidth  read data for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: as above, for requester 1.
- busy  out  1  init sweep in progress; no grants while high.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  AddrWidth  RAM port address.
- ram_din  out  DataWidth  RAM port write data.
- ram_dout  in  DataWidth  RAM port read data (registered inside the RAM, 1-cycle latency).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Values while reset is high: gnt0/1=0, rvalid0/1=0, ram_en=0, ram_we=0, init counter=0, last-granted pointer=1 (so requester 0 wins the first tie), busy=InitOnReset.
- Reset mid-operation: abandons any sweep or access and restarts from the reset state. No rvalid is produced for a read granted in the cycle reset is sampled.

State machine (INIT, RUN):
- INIT:
  - Every cycle: ram_en=1, ram_we=1, ram_addr=counter, ram_din=InitValue.
  - Counter increments each cycle from 0 to 2**AddrWidth-1.
  - On the cycle it writes the last address, next state = RUN.
  - busy=1 for exactly 2**AddrWidth cycles starting the first cycle after reset deasserts.
  - gnt0/1=0 throughout. Requests are held, not dropped.
- RUN:
  - busy=0.
  - Grant is decided combinationally each cycle from req0/req1 and the pointer; at most one grant per cycle.
  - Only req0: gnt0. Only req1: gnt1. Both: grant the requester not granted last.
  - Pointer updates on every grant.
  - Granted requester's we/addr/wdata are muxed to ram_we/ram_addr/ram_din with ram_en=1.
  - No grant: ram_en=0, ram_we=0; ram_addr/ram_din hold the muxed requester-0 values (don't-care).

Handshake:
- Requester holds req/we/addr/wdata stable until it sees gnt in the same cycle.
- Requester may drop req or change fields on the cycle after gnt, or keep req high for back-to-back accesses.
- A continuous single requester gets one grant every cycle.

Read return:
- rvalidN is registered: set the cycle after a read grant (gntN & ~weN), otherwise 0.
- rdataN = ram_dout combinationally. Both rdata outputs carry ram_dout; only rvalid qualifies them.
- Back-to-back reads return back-to-back data, in grant order.

Write timing:
- Data is written on the grant-cycle edge. No response is produced.
- A read of the same address on the next grant returns the new value.

Boundaries:
- Address 2**AddrWidth-1 is handled identically to any other address.
- Counter terminal compare uses the full AddrWidth; the counter does not wrap during INIT.

Test Plan:
- Init sweep: deassert reset with InitOnReset=1. Expect busy=1 for 4096 cycles with ram_addr 0..4095, ram_we=1, ram_din=0. busy=0 on cycle 4097. req0 held since cycle 1 gets gnt0 on cycle 4097.
- Write then read: req0 write addr 0xFFF data 0x1A5; next cycle req0 read 0xFFF. Expect gnt0 both cycles, rvalid0=1 and rdata0=0x1A5 one cycle after the read grant. rvalid1 stays 0.
- Contention: req0 and req1 held high for 6 reads to distinct addresses. Expect grants 0,1,0,1,0,1 (first tie to 0). Each rvalid lands the cycle after its own grant.
- Single streaming requester: req1 high 8 cycles, req0 idle. Expect gnt1 every cycle and 8 consecutive rvalid1 pulses in address order.
- Reset mid-sweep: assert reset at counter=1000 for 1 cycle. Expect ram_en=0 during the reset cycle, sweep restarting at address 0, and busy high for a full 4096 cycles again.
- Reset on a read grant: reset sampled in the cycle gnt0 (read) is issued. Expect rvalid0=0 next cycle and INIT restarting.
